// File: rtl/sum_drain_pkg.sv
// Shared definitions for the systolic-array result drain: lane width,
// default lane count and the drain control states.
package sum_drain_pkg;

    localparam int LANE_W           = 32;
    localparam int DEF_ARRAY_LENGTH = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_t;

    // Counter width that stays legal when a count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_drain_vec.sv
// Vector FIFO: whole result vectors with a fall-through head read.
// The caller decides acceptance; push is only asserted when a slot is free or being popped.
module vec_fifo
    import sum_drain_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full
);

    localparam int PW = cnt_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Storage carries no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/sum_drain.sv
// Captures result vectors from the systolic array and serialises them lane by
// lane onto a 32-bit valid/ready stream, flagging any vector lost to overrun.
module sum_drain
    import sum_drain_pkg::*;
#(
    parameter int ARRAY_LENGTH = DEF_ARRAY_LENGTH,
    parameter int DEPTH        = 4
) (
    input  logic                             clk,
    input  logic                             res,
    input  logic [ARRAY_LENGTH*LANE_W-1:0]   SoutL,
    input  logic                             Sready,
    output logic [LANE_W-1:0]                Dout,
    output logic                             Dvalid,
    input  logic                             Dready,
    output logic                             Dlast,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             full,
    output logic                             overflow
);

    localparam int CW = cnt_width(ARRAY_LENGTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int VW = ARRAY_LENGTH * LANE_W;

    drain_state_t            state_q, state_d;
    logic [CW-1:0]           lane_cnt_q, lane_cnt_d;
    logic                    overflow_q, overflow_d;

    logic [VW-1:0]           head;
    logic [LW-1:0]           fifo_level;
    logic                    fifo_full;
    logic                    last_lane;
    logic                    xfer;
    logic                    pop;
    logic                    push;
    logic [LANE_W-1:0]       lanes [ARRAY_LENGTH];

    assign Dvalid    = (state_q == ST_STREAM);
    assign last_lane = (lane_cnt_q == CW'(ARRAY_LENGTH - 1));
    assign xfer      = Dvalid && Dready;
    assign pop       = xfer && last_lane;
    // A full buffer can still take a vector when its head leaves on this edge.
    assign push      = Sready && (!fifo_full || pop);

    vec_fifo #(
        .W     (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .din   (SoutL),
        .head  (head),
        .level (fifo_level),
        .full  (fifo_full)
    );

    for (genvar gi = 0; gi < ARRAY_LENGTH; gi++) begin : g_lane
        assign lanes[gi] = head[gi*LANE_W +: LANE_W];
    end

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        overflow_d = overflow_q;
        if (xfer) begin
            lane_cnt_d = last_lane ? '0 : lane_cnt_q + CW'(1);
        end
        if (Sready && !push) begin
            overflow_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop && fifo_level == LW'(1) && !push) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign Dout     = Dvalid ? lanes[lane_cnt_q] : '0;
    assign Dlast    = Dvalid && last_lane;
    assign level    = fifo_level;
    assign full     = fifo_full;
    assign overflow = overflow_q;

endmodule
